// File: rtl/irb_scanout.sv
// irb_scanout: captures the 8x8 IRB write stream into a local frame store and, on a rising
// edge of done, streams the frame out in raster order. Optional macro: IRB_SCAN_MIRROR_EN.
module irb_scanout #(
    parameter int AW       = 6,
    parameter int DW       = 8,
    parameter int LAST_IDX = 63
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          IRB_RW,
    input  logic [AW-1:0] IRB_A,
    input  logic [DW-1:0] IRB_D,
    input  logic          done,
`ifdef IRB_SCAN_MIRROR_EN
    input  logic          mirror,
`endif
    input  logic          scan_ready,
    output logic          pix_valid,
    output logic [DW-1:0] pix_data,
    output logic [2:0]    pix_x,
    output logic [2:0]    pix_y,
    output logic          frame_start,
    output logic          frame_end,
    output logic [15:0]   checksum,
    output logic          wr_err,
    output logic          scan_busy,
    output logic [1:0]    o_dbg_state
);

    // Handshake: a pixel transfers on a posedge where pix_valid && scan_ready; while
    // pix_valid is high, pix_data/pix_x/pix_y stay stable; scan_ready is ignored otherwise.

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SHOW   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_idx;
    logic [15:0]     r_acc;
    logic            r_done_q;
    logic            r_pix_valid;
    logic [DW-1:0]   r_pix_data;
    logic [2:0]      r_pix_x;
    logic [2:0]      r_pix_y;
    logic            r_frame_start;
    logic            r_frame_end;
    logic [15:0]     r_checksum;
    logic            r_wr_err;
    logic            r_scan_busy;
    logic            r_mirror;

    logic            w_start;
    logic            w_write;
    logic            w_accept;
    logic            w_last;
    logic [AW-1:0]   w_rd_addr;
    logic [DW-1:0]   w_rd_data;

    assign w_start  = done & ~r_done_q;
    assign w_write  = ~IRB_RW;
    assign w_accept = r_pix_valid & scan_ready;
    assign w_last   = (r_idx == AW'(LAST_IDX));

`ifdef IRB_SCAN_MIRROR_EN
    assign w_rd_addr = r_mirror ? {r_idx[AW-1:3], ~r_idx[2:0]} : r_idx;
`else
    assign r_mirror  = 1'b0;
    assign w_rd_addr = r_idx;
`endif
    assign w_rd_data = r_mem[w_rd_addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = FETCH;
            FETCH:   w_next = SHOW;
            SHOW:    if (w_accept) w_next = w_last ? FINISH : FETCH;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_idx         <= '0;
            r_acc         <= '0;
            r_done_q      <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_pix_data    <= '0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_checksum    <= '0;
            r_wr_err      <= 1'b0;
            r_scan_busy   <= 1'b0;
        end else begin
            r_done_q      <= done;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            // Writes outside IDLE would tear the frame being streamed, so they are dropped and flagged.
            if (w_write && r_state != IDLE) r_wr_err <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_write) r_mem[IRB_A] <= IRB_D;
                    if (w_start) begin
                        r_idx       <= '0;
                        r_acc       <= '0;
                        r_scan_busy <= 1'b1;
                        r_wr_err    <= 1'b0;
                    end
                end
                FETCH: begin
                    r_pix_data    <= w_rd_data;
                    r_pix_x       <= r_idx[2:0];
                    r_pix_y       <= r_idx[5:3];
                    r_pix_valid   <= 1'b1;
                    r_acc         <= r_acc + 16'(w_rd_data);
                    r_frame_start <= (r_idx == '0);
                end
                SHOW: begin
                    if (w_accept) begin
                        r_pix_valid <= 1'b0;
                        if (!w_last) r_idx <= r_idx + AW'(1);
                    end
                end
                FINISH: begin
                    r_frame_end <= 1'b1;
                    r_checksum  <= r_acc;
                    r_scan_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef IRB_SCAN_MIRROR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mirror <= 1'b0;
        end else if (r_state == IDLE && w_start) begin
            r_mirror <= mirror;
        end
    end
`endif

    assign pix_valid   = r_pix_valid;
    assign pix_data    = r_pix_data;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign checksum    = r_checksum;
    assign wr_err      = r_wr_err;
    assign scan_busy   = r_scan_busy;
    assign o_dbg_state = r_state;

endmodule
